// File: rtl/sig_to_double_mc.sv
// sig_to_double_mc
//   Multi-channel converter from signed SIG_W-bit integers to IEEE-754 binary64.
//   Channels are converted one after another by a single shift-normalise
//   datapath, so a request costs 2*N_CH + sum(leading zeros) + 1 cycles.
//
// Ports
//   clk_operation : single clock, rising edge
//   rst           : synchronous, active-high reset
//   enable        : conversion request, accepted only while idle
//   sig           : N_CH packed two's-complement samples, channel c at [c*SIG_W +: SIG_W]
//   double        : N_CH packed binary64 results, channel c at [c*64 +: 64]
//   ready         : one-cycle completion strobe
//   busy          : high whenever a conversion is in progress
//   state_dbg     : FSM state (IDLE=0, LOAD=1, NORM=2, STORE=3, DONE=4)
//
// Handshake: a request is taken on any rising edge where enable=1 and the FSM
// is idle (busy=0); sig is captured on that edge. enable is ignored otherwise.
// ready rises for exactly one cycle once every field of double holds the
// result of that request; there is no back-pressure on ready.

module sig_to_double_mc #(
    parameter int SIG_W = 16,
    parameter int N_CH  = 2
) (
    input  logic                   clk_operation,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_CH*SIG_W-1:0]  sig,
    output logic [N_CH*64-1:0]     double,
    output logic                   ready,
    output logic                   busy,
    output logic [2:0]             state_dbg
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(SIG_W);
    localparam int PAD_W = 53 - SIG_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NORM  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [N_CH*SIG_W-1:0]  sig_q;
    logic [CH_W-1:0]        ch_idx;
    logic [SIG_W-1:0]       mag;
    logic                   sign_q;
    logic [CNT_W-1:0]       shift_cnt;

    logic [SIG_W-1:0]       cur_x;
    logic [SIG_W-1:0]       cur_mag;
    logic                   last_ch;
    logic [63:0]            result;

    // Current channel sample and its magnitude. Negating the most negative
    // value wraps to 2^(SIG_W-1), which is the correct unsigned magnitude.
    always_comb begin
        cur_x = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                cur_x = sig_q[c*SIG_W +: SIG_W];
            end
        end
        cur_mag = cur_x[SIG_W-1] ? (~cur_x + SIG_W'(1)) : cur_x;
        last_ch = (ch_idx == CH_W'(N_CH-1));
    end

    // Normalised magnitude has its MSB set; that bit is the implicit one and
    // the bits below it become the left-aligned fraction. Zero maps to +0.
    always_comb begin
        result = '0;
        if (mag != '0) begin
            result = {sign_q,
                      11'(1022 + SIG_W) - 11'(shift_cnt),
                      mag[SIG_W-2:0], {PAD_W{1'b0}}};
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = LOAD;
            // Zero or already-normalised magnitudes need no shifting.
            LOAD:    state_nxt = (cur_mag == '0 || cur_mag[SIG_W-1]) ? STORE : NORM;
            // Leave once this shift brings a one into the MSB.
            NORM:    if (mag[SIG_W-2]) state_nxt = STORE;
            STORE:   state_nxt = last_ch ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            sig_q     <= '0;
            ch_idx    <= '0;
            mag       <= '0;
            sign_q    <= 1'b0;
            shift_cnt <= '0;
            double    <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= (state == DONE);
            case (state)
                IDLE: begin
                    if (enable) begin
                        sig_q  <= sig;
                        ch_idx <= '0;
                    end
                end
                LOAD: begin
                    sign_q    <= cur_x[SIG_W-1];
                    mag       <= cur_mag;
                    shift_cnt <= '0;
                end
                NORM: begin
                    mag       <= mag << 1;
                    shift_cnt <= shift_cnt + 1'b1;
                end
                STORE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (ch_idx == CH_W'(c)) begin
                            double[c*64 +: 64] <= result;
                        end
                    end
                    if (!last_ch) begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sig_to_double_mc.sv
// tb_sig_to_double_mc
//   Bench for sig_to_double_mc. Several instances with different SIG_W/N_CH
//   share clock and reset; each has its own request/sample/result signals.
//   Expected results come from $realtobits of the integer value and expected
//   latency from the leading-zero count of each magnitude.

module tb_sig_to_double_mc;

    localparam int NI = 7;

    function automatic int w_of(input int i);
        case (i)
            0:       return 16;
            1, 2:    return 8;
            3, 4:    return 24;
            default: return 32;
        endcase
    endfunction

    function automatic int n_of(input int i);
        case (i)
            0:        return 2;
            1, 3, 5:  return 1;
            default:  return 4;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NI-1:0]   en_v;
    logic [255:0]    sig_w [NI];
    logic [511:0]    dbl_w [NI];
    logic [NI-1:0]   rdy_v;
    logic [NI-1:0]   bsy_v;
    logic [2:0]      st_w  [NI];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = w_of(g);
        localparam int N = n_of(g);
        logic [N*64-1:0] d;
        logic            r;
        logic            b;
        logic [2:0]      st;

        sig_to_double_mc #(.SIG_W(W), .N_CH(N)) u_dut (
            .clk_operation (clk),
            .rst           (rst),
            .enable        (en_v[g]),
            .sig           (sig_w[g][N*W-1:0]),
            .double        (d),
            .ready         (r),
            .busy          (b),
            .state_dbg     (st)
        );

        assign dbl_w[g] = 512'(d);
        assign rdy_v[g] = r;
        assign bsy_v[g] = b;
        assign st_w[g]  = st;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Leading zeros of |v| in w bits; zero contributes no normalisation.
    function automatic int lz(input longint v, input int w);
        longint m;
        int p;
        m = (v < 0) ? -v : v;
        if (m == 0) return 0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return w - 1 - p;
    endfunction

    function automatic longint rand_val(input int w);
        longint lim;
        longint u;
        logic [63:0] mask;
        lim  = longint'(1) << (w - 1);
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 9))
            0: return 0;
            1: return -lim;
            2: return lim - 1;
            3: return 1;
            4: return -1;
            5: return longint'($urandom_range(0, 7)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            default: begin
                u = longint'({$urandom, $urandom} & mask);
                if (u >= lim) u = u - 2 * lim;
                return u;
            end
        endcase
    endfunction

    function automatic logic [63:0] field(input int idx, input int c);
        logic [511:0] tmp;
        tmp = dbl_w[idx] >> (c * 64);
        return tmp[63:0];
    endfunction

    // ---------------- driver: one request, checked end to end ----------------
    task automatic run_conv(input int idx, input longint vals[8], input string tag,
                            output bit norm_seen);
        int w;
        int n;
        int t;
        int cyc;
        logic [255:0] acc;
        logic [63:0]  u;
        logic [63:0]  mask;
        w = w_of(idx);
        n = n_of(idx);
        mask = (64'd1 << w) - 64'd1;
        acc = '0;
        t = 2 * n + 1;
        norm_seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            u   = 64'(vals[c]) & mask;
            acc = acc | (256'(u) << (c * w));
            t  += lz(vals[c], w);
        end
        @(negedge clk);
        sig_w[idx] = acc;
        en_v[idx]  = 1'b1;
        @(posedge clk);                 // edge 0: request sampled
        @(negedge clk);
        en_v[idx]  = 1'b0;
        sig_w[idx] = ~acc;              // must not disturb the captured samples
        check({tag, " busy"}, 64'(bsy_v[idx]), 64'd1);
        cyc = 0;
        while (!rdy_v[idx] && cyc < t + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (st_w[idx] == 3'd2) norm_seen = 1'b1;
        end
        check({tag, " latency"}, 64'(cyc), 64'(t));
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s ch%0d", tag, c), field(idx, c), $realtobits(real'(vals[c])));
        end
        @(negedge clk);
        check({tag, " ready_pulse"}, 64'(rdy_v[idx]), 64'd0);
        check({tag, " idle"}, 64'(bsy_v[idx]), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        longint v[8];
        bit ns;
        int cnt;
        int exp_cnt;
        logic [63:0] e0;
        logic [63:0] e1;

        rst  = 1'b1;
        en_v = '0;
        for (int i = 0; i < NI; i++) sig_w[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset ch0", field(0, 0), 64'h0);
        check("reset ch1", field(0, 1), 64'h0);
        check("reset ready", 64'(rdy_v[0]), 64'd0);
        check("reset busy", 64'(bsy_v[0]), 64'd0);
        check("reset state", 64'(st_w[0]), 64'd0);

        // +1 / -1: full 15-cycle normalisation on each channel
        v = '{default: 0};
        v[0] = 1;
        v[1] = -1;
        run_conv(0, v, "pm_one", ns);
        check("pm_one const ch0", field(0, 0), 64'h3FF0000000000000);
        check("pm_one const ch1", field(0, 1), 64'hBFF0000000000000);

        // extremes, no normalisation
        v = '{default: 0};
        v[0] = 32767;
        v[1] = -32768;
        run_conv(0, v, "extreme", ns);
        e0 = 64'h40DFFFC000000000;
        e1 = 64'hC0E0000000000000;
        check("extreme const ch0", field(0, 0), e0);
        check("extreme const ch1", field(0, 1), e1);
        repeat (5) @(negedge clk);
        check("hold ch0", field(0, 0), e0);
        check("hold ch1", field(0, 1), e1);

        // zeros skip normalisation entirely
        v = '{default: 0};
        run_conv(0, v, "zero", ns);
        check("zero no_norm", 64'(ns), 64'd0);

        // enable held high: one conversion per return to idle
        @(negedge clk);
        sig_w[0] = '0;
        en_v[0]  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy_v[0]) cnt++;
        end
        en_v[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy_v[0]) cnt++;
        end
        exp_cnt = (40 + 5) / (5 + 1);
        check("held_enable readies", 64'(cnt), 64'(exp_cnt));

        // reset in the middle of normalisation
        @(negedge clk);
        sig_w[0] = {16'h0001, 16'h0001};
        en_v[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort in_norm", 64'(st_w[0]), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort ch0", field(0, 0), 64'h0);
        check("abort ch1", field(0, 1), 64'h0);
        check("abort busy", 64'(bsy_v[0]), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy_v[0]) cnt++;
        end
        check("abort no_ready", 64'(cnt), 64'd0);
        v = '{default: 0};
        v[0] = rand_val(16);
        v[1] = rand_val(16);
        run_conv(0, v, "after_abort", ns);

        // random sweep over every configuration
        for (int idx = 0; idx < NI; idx++) begin
            for (int r = 0; r < 100; r++) begin
                v = '{default: 0};
                for (int c = 0; c < n_of(idx); c++) v[c] = rand_val(w_of(idx));
                run_conv(idx, v, $sformatf("rnd w%0d n%0d #%0d", w_of(idx), n_of(idx), r), ns);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
